alu_reservation_station: RTL and testbench
==========================================

# alu_reservation_station

Age-ordered reservation station feeding the single arithmetic execute unit of the Tomasulo core. It accepts decoded ALU micro-ops from dispatch with operands that are either ready or pending on a producer tag. It snoops the common data bus (CDB) to wake pending operands. Each cycle it offers the oldest fully-ready entry to the ALU over a valid/ready handshake.

## Interface
- NUM_ENTRIES, 4: station depth, ≥2.
- TAG_W, 4: producer/destination tag width.
- CNT_W, $clog2(NUM_ENTRIES+1): occupancy width.

- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all entries.
- in_valid  in  1  dispatch request.
- in_ready  out  1  station can accept (not full).
- in_aluop  in  5  ALU op code (alu_op_t encoding).
- in_vala / in_valb  in  64 each  operand values, meaningful when the matching rdy is 1.
- in_vala_rdy / in_valb_rdy  in  1 each  operand already available.
- in_vala_tag / in_valb_tag  in  TAG_W each  producer tag when not ready.
- in_valhw  in  6  shift amount for MOV.
- in_set_cc  in  1  update flags.
- in_cond  in  4  condition (cond_t).
- in_dst_tag  in  TAG_W  result tag.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_value  in  64  broadcast value.
- alu_valid  out  1  issue offer.
- alu_ready  in  1  ALU accepts offer.
- alu_op, alu_vala, alu_valb, alu_valhw, alu_set_cc, alu_cond, alu_dst_tag  out  widths as the in_* ports  issued micro-op.
- count  out  CNT_W  valid entries.

## Operation
- Storage is a collapsing queue. Slot 0 is the oldest entry. Valid entries are contiguous in slots 0..count-1.
- Each entry holds all in_* fields plus per-operand rdy bits.
- Entry ready = valid & a_rdy & b_rdy.
- Select: alu_* presents the lowest-index ready entry, and alu_valid=1 if one exists.
  - When alu_valid=0, all alu_* data outputs are 0.
  - Outputs derive only from registered state. There is no combinational path from alu_ready, in_valid or cdb_* to any output.
- Issue fire = alu_valid & alu_ready. At the edge, the selected slot is removed and younger slots shift down one.
- While alu_valid=1 and alu_ready=0, the offered entry may change to an older entry that becomes ready. The ALU consumes only on fire.
- Dispatch fire = in_valid & in_ready. The new entry is written at slot count, or at slot count-1 if issue fires in the same cycle.
- in_ready = (count != NUM_ENTRIES). A full station does not accept even if issue fires that cycle.
- Wakeup: when cdb_valid=1, every valid entry with a non-ready operand whose tag equals cdb_tag captures cdb_value and sets rdy.
  - This applies to both operands independently, including an entry that is shifting that cycle.
- Dispatch bypass: an incoming non-ready operand whose tag equals cdb_tag while cdb_valid=1 is stored ready with cdb_value.
- Tags on ready operands are ignored.
- flush=1 at an edge: all entries become invalid and count=0. Flush overrides same-cycle dispatch and wakeup.
  - An issue fire in the flush cycle still completes at the ALU, but the entry is discarded anyway.
- count update: +1 on dispatch fire, -1 on issue fire, unchanged when both fire.

## Timing
- Reset values: count=0, in_ready=1, alu_valid=0, all alu_* data=0, all entries invalid.
- Dispatch of a fully ready op in cycle t: alu_valid=1 in cycle t+1 if it is the oldest ready entry.
- CDB broadcast in cycle t: the woken entry becomes eligible in cycle t+1.
- Issue fire in cycle t: the entry is gone in t+1, count is decremented in t+1, and in_ready rises in t+1 if the station was full.
- Asserting rst mid-operation immediately clears all state to the reset values, independent of clk.

## Test plan
- Reset: assert rst asynchronously mid-cycle with 2 entries held → count=0, alu_valid=0, in_ready=1 immediately.
- Basic issue: dispatch PLUS_OP with vala=5, valb=7 (both ready), dst_tag=3, alu_ready=1 at cycle t → in cycle t+1 alu_valid=1, alu_vala=5, alu_valb=7, alu_dst_tag=3; in cycle t+2 count=0.
- Wakeup: dispatch with valb pending on tag 6; cdb tag 5 (value 0x99) at t+1 → no issue; cdb tag 6, value 0x10 at t+2 → alu_valid=1 at t+3 with alu_valb=0x10. Separately, dispatch pending on tag 9 while cdb_valid with tag 9, value 0x42 → issues next cycle with operand 0x42.
- Age order: alu_ready=0; dispatch A (vala pending on tag 2), then B and C (ready).
  - Offer is B.
  - cdb tag 2 → offer becomes A.
  - Raise alu_ready → fires A, B, C on consecutive cycles.
- Full/simultaneous: 4 ready dispatches with alu_ready=0 → count=4, in_ready=0, and a 5th in_valid is dropped. One fire → in_ready=1 next cycle. Then same-cycle dispatch and fire → count stays 3, and the new entry lands in slot 2.
- Flush: 3 entries plus in_valid and a matching cdb in the same cycle as flush=1 → next cycle count=0, alu_valid=0, in_ready=1.

Source files
------------

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - age-ordered collapsing reservation station for the ALU issue port
module alu_reservation_station #(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = 4,
    parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_aluop,
    input  logic [63:0]      in_vala,
    input  logic [63:0]      in_valb,
    input  logic             in_vala_rdy,
    input  logic             in_valb_rdy,
    input  logic [TAG_W-1:0] in_vala_tag,
    input  logic [TAG_W-1:0] in_valb_tag,
    input  logic [5:0]       in_valhw,
    input  logic             in_set_cc,
    input  logic [3:0]       in_cond,
    input  logic [TAG_W-1:0] in_dst_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [63:0]      cdb_value,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [4:0]       alu_op,
    output logic [63:0]      alu_vala,
    output logic [63:0]      alu_valb,
    output logic [5:0]       alu_valhw,
    output logic             alu_set_cc,
    output logic [3:0]       alu_cond,
    output logic [TAG_W-1:0] alu_dst_tag,
    output logic [CNT_W-1:0] count
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef struct packed {
        logic [4:0]       op;
        logic [63:0]      vala;
        logic             a_rdy;
        logic [TAG_W-1:0] a_tag;
        logic [63:0]      valb;
        logic             b_rdy;
        logic [TAG_W-1:0] b_tag;
        logic [5:0]       valhw;
        logic             set_cc;
        logic [3:0]       cond;
        logic [TAG_W-1:0] dst_tag;
    } entry_t;

    entry_t           ent_q [NUM_ENTRIES];
    entry_t           ent_d [NUM_ENTRIES];
    entry_t           woke  [NUM_ENTRIES];
    entry_t           new_ent;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             issue_fire;
    logic             disp_fire;
    logic             a_hit;
    logic             b_hit;

    assign count      = count_q;
    assign in_ready   = (count_q != CNT_W'(NUM_ENTRIES));
    assign alu_valid  = sel_found;
    assign issue_fire = sel_found & alu_ready;
    assign disp_fire  = in_valid & in_ready;
    assign wr_idx     = count_q - CNT_W'(issue_fire);

    // Oldest ready entry wins; valid slots are always 0..count-1.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!sel_found && (CNT_W'(i) < count_q) && ent_q[i].a_rdy && ent_q[i].b_rdy) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            woke[i] = ent_q[i];
            if (cdb_valid && !ent_q[i].a_rdy && (ent_q[i].a_tag == cdb_tag)) begin
                woke[i].vala  = cdb_value;
                woke[i].a_rdy = 1'b1;
            end
            if (cdb_valid && !ent_q[i].b_rdy && (ent_q[i].b_tag == cdb_tag)) begin
                woke[i].valb  = cdb_value;
                woke[i].b_rdy = 1'b1;
            end
        end
    end

    // Incoming operands still pending can be satisfied by this cycle's broadcast.
    always_comb begin
        a_hit           = cdb_valid & ~in_vala_rdy & (in_vala_tag == cdb_tag);
        b_hit           = cdb_valid & ~in_valb_rdy & (in_valb_tag == cdb_tag);
        new_ent.op      = in_aluop;
        new_ent.vala    = a_hit ? cdb_value : in_vala;
        new_ent.a_rdy   = in_vala_rdy | a_hit;
        new_ent.a_tag   = in_vala_tag;
        new_ent.valb    = b_hit ? cdb_value : in_valb;
        new_ent.b_rdy   = in_valb_rdy | b_hit;
        new_ent.b_tag   = in_valb_tag;
        new_ent.valhw   = in_valhw;
        new_ent.set_cc  = in_set_cc;
        new_ent.cond    = in_cond;
        new_ent.dst_tag = in_dst_tag;
    end

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ent_d[i] = woke[i];
        end
        for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
            if (issue_fire && (IDX_W'(i) >= sel_idx)) begin
                ent_d[i] = woke[i + 1];
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (disp_fire && (CNT_W'(i) == wr_idx)) begin
                ent_d[i] = new_ent;
            end
        end
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    always_comb begin
        alu_op      = '0;
        alu_vala    = '0;
        alu_valb    = '0;
        alu_valhw   = '0;
        alu_set_cc  = 1'b0;
        alu_cond    = '0;
        alu_dst_tag = '0;
        if (sel_found) begin
            alu_op      = ent_q[sel_idx].op;
            alu_vala    = ent_q[sel_idx].vala;
            alu_valb    = ent_q[sel_idx].valb;
            alu_valhw   = ent_q[sel_idx].valhw;
            alu_set_cc  = ent_q[sel_idx].set_cc;
            alu_cond    = ent_q[sel_idx].cond;
            alu_dst_tag = ent_q[sel_idx].dst_tag;
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - scoreboard bench for alu_reservation_station
module tb_alu_reservation_station;
    localparam logic [4:0] PLUS_OP = 5'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_aluop = '0;
    logic [63:0] in_vala = '0;
    logic [63:0] in_valb = '0;
    logic        in_vala_rdy = 1'b0;
    logic        in_valb_rdy = 1'b0;
    logic [3:0]  in_vala_tag = '0;
    logic [3:0]  in_valb_tag = '0;
    logic [5:0]  in_valhw = '0;
    logic        in_set_cc = 1'b0;
    logic [3:0]  in_cond = '0;
    logic [3:0]  in_dst_tag = '0;
    logic        cdb_valid = 1'b0;
    logic [3:0]  cdb_tag = '0;
    logic [63:0] cdb_value = '0;
    logic        alu_valid;
    logic        alu_ready = 1'b0;
    logic [4:0]  alu_op;
    logic [63:0] alu_vala;
    logic [63:0] alu_valb;
    logic [5:0]  alu_valhw;
    logic        alu_set_cc;
    logic [3:0]  alu_cond;
    logic [3:0]  alu_dst_tag;
    logic [2:0]  count;

    typedef struct {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  hw;
        logic        cc;
        logic [3:0]  cond;
        logic [3:0]  dst;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    alu_reservation_station #(.NUM_ENTRIES(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluop(in_aluop),
        .in_vala(in_vala), .in_valb(in_valb),
        .in_vala_rdy(in_vala_rdy), .in_valb_rdy(in_valb_rdy),
        .in_vala_tag(in_vala_tag), .in_valb_tag(in_valb_tag),
        .in_valhw(in_valhw), .in_set_cc(in_set_cc), .in_cond(in_cond),
        .in_dst_tag(in_dst_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_vala(alu_vala), .alu_valb(alu_valb), .alu_valhw(alu_valhw),
        .alu_set_cc(alu_set_cc), .alu_cond(alu_cond), .alu_dst_tag(alu_dst_tag),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic idle();
        in_valid  = 1'b0;
        cdb_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [63:0] val);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_value = val;
    endtask

    task automatic set_disp(input logic [4:0] op,
                            input logic [63:0] a, input logic ar, input logic [3:0] at,
                            input logic [63:0] b, input logic br, input logic [3:0] bt,
                            input logic [3:0] dst, input bit push,
                            input logic [63:0] ea, input logic [63:0] eb);
        exp_t x;
        in_valid    = 1'b1;
        in_aluop    = op;
        in_vala     = a;
        in_vala_rdy = ar;
        in_vala_tag = at;
        in_valb     = b;
        in_valb_rdy = br;
        in_valb_tag = bt;
        in_dst_tag  = dst;
        in_valhw    = {1'b0, dst, 1'b1};
        in_set_cc   = dst[0];
        in_cond     = ~dst;
        if (push) begin
            x.op = op; x.a = ea; x.b = eb; x.dst = dst;
            x.hw = {1'b0, dst, 1'b1}; x.cc = dst[0]; x.cond = ~dst;
            sb.push_back(x);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        alu_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (count !== 3'd0 || in_ready !== 1'b1 || alu_valid !== 1'b0 || alu_vala !== 64'd0 || alu_dst_tag !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: count=%0d in_ready=%0b alu_valid=%0b vala=%0h dst=%0h, want 0 1 0 0 0",
                     count, in_ready, alu_valid, alu_vala, alu_dst_tag);
        end
        set_disp(PLUS_OP, 64'h11, 1, 0, 64'h12, 1, 0, 4'd1, 0, 0, 0);
        @(negedge clk);
        set_disp(PLUS_OP, 64'h21, 1, 0, 64'h22, 1, 0, 4'd2, 0, 0, 0);
        @(negedge clk);
        idle();
        vectors++;
        if (count !== 3'd2 || alu_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_prefill: count=%0d alu_valid=%0b, want 2 1", count, alu_valid);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (count !== 3'd0 || alu_valid !== 1'b0 || in_ready !== 1'b1 || alu_vala !== 64'd0) begin
            miscompares++;
            $display("FAIL async_reset: count=%0d alu_valid=%0b in_ready=%0b vala=%0h, want 0 0 1 0",
                     count, alu_valid, in_ready, alu_vala);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        alu_ready = 1'b1;
        set_disp(PLUS_OP, 64'd5, 1, 0, 64'd7, 1, 0, 4'd3, 1, 64'd5, 64'd7);
        @(negedge clk);
        idle();
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL basic_issue: scoreboard empty, alu_valid=%0b", alu_valid);
        end else begin
            e = sb.pop_front();
            if (alu_valid !== 1'b1 || alu_op !== e.op || alu_vala !== e.a || alu_valb !== e.b ||
                alu_valhw !== e.hw || alu_set_cc !== e.cc || alu_cond !== e.cond || alu_dst_tag !== e.dst) begin
                miscompares++;
                $display("FAIL basic_issue: got v=%0b op=%0h a=%0h b=%0h hw=%0h cc=%0b cond=%0h dst=%0h, want v=1 op=%0h a=%0h b=%0h hw=%0h cc=%0b cond=%0h dst=%0h",
                         alu_valid, alu_op, alu_vala, alu_valb, alu_valhw, alu_set_cc, alu_cond, alu_dst_tag,
                         e.op, e.a, e.b, e.hw, e.cc, e.cond, e.dst);
            end
        end
        @(negedge clk);
        vectors++;
        if (count !== 3'd0 || alu_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_drain: count=%0d alu_valid=%0b, want 0 0", count, alu_valid);
        end
    endtask

    task automatic test_wakeup();
        alu_ready = 1'b1;
        set_disp(PLUS_OP, 64'd1, 1, 0, 64'hBAD, 0, 4'd6, 4'd7, 1, 64'd1, 64'h10);
        @(negedge clk);
        idle();
        cdb(4'd5, 64'h99);
        vectors++;
        if (alu_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_pending: alu_valid=%0b, want 0", alu_valid);
        end
        @(negedge clk);
        cdb(4'd6, 64'h10);
        vectors++;
        if (alu_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wake_wrong_tag: alu_valid=%0b, want 0", alu_valid);
        end
        @(negedge clk);
        idle();
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL wake_issue: scoreboard empty, alu_valid=%0b", alu_valid);
        end else begin
            e = sb.pop_front();
            if (alu_valid !== 1'b1 || alu_vala !== e.a || alu_valb !== e.b || alu_dst_tag !== e.dst) begin
                miscompares++;
                $display("FAIL wake_issue: got v=%0b a=%0h b=%0h dst=%0h, want v=1 a=%0h b=%0h dst=%0h",
                         alu_valid, alu_vala, alu_valb, alu_dst_tag, e.a, e.b, e.dst);
            end
        end
        @(negedge clk);
        set_disp(PLUS_OP, 64'd2, 1, 0, 64'hDEAD, 0, 4'd9, 4'd8, 1, 64'd2, 64'h42);
        cdb(4'd9, 64'h42);
        @(negedge clk);
        idle();
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL bypass_issue: scoreboard empty, alu_valid=%0b", alu_valid);
        end else begin
            e = sb.pop_front();
            if (alu_valid !== 1'b1 || alu_vala !== e.a || alu_valb !== e.b || alu_dst_tag !== e.dst) begin
                miscompares++;
                $display("FAIL bypass_issue: got v=%0b a=%0h b=%0h dst=%0h, want v=1 a=%0h b=%0h dst=%0h",
                         alu_valid, alu_vala, alu_valb, alu_dst_tag, e.a, e.b, e.dst);
            end
        end
        @(negedge clk);
        vectors++;
        if (count !== 3'd0) begin
            miscompares++;
            $display("FAIL bypass_drain: count=%0d, want 0", count);
        end
    endtask

    task automatic test_age_order();
        alu_ready = 1'b0;
        set_disp(5'd4, 64'hBAD, 0, 4'd2, 64'h22, 1, 0, 4'd1, 1, 64'hAA, 64'h22);
        @(negedge clk);
        set_disp(5'd5, 64'h31, 1, 0, 64'h32, 1, 0, 4'd2, 1, 64'h31, 64'h32);
        @(negedge clk);
        set_disp(5'd6, 64'h41, 1, 0, 64'h42, 1, 0, 4'd3, 1, 64'h41, 64'h42);
        @(negedge clk);
        idle();
        vectors++;
        if (alu_valid !== 1'b1 || alu_dst_tag !== 4'd2 || count !== 3'd3) begin
            miscompares++;
            $display("FAIL offer_b: v=%0b dst=%0h count=%0d, want 1 2 3", alu_valid, alu_dst_tag, count);
        end
        cdb(4'd2, 64'hAA);
        @(negedge clk);
        idle();
        vectors++;
        if (alu_valid !== 1'b1 || alu_dst_tag !== 4'd1) begin
            miscompares++;
            $display("FAIL offer_a: v=%0b dst=%0h, want 1 1", alu_valid, alu_dst_tag);
        end
        alu_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL age_issue%0d: scoreboard empty, alu_valid=%0b", k, alu_valid);
            end else begin
                e = sb.pop_front();
                if (alu_valid !== 1'b1 || alu_op !== e.op || alu_vala !== e.a || alu_valb !== e.b || alu_dst_tag !== e.dst) begin
                    miscompares++;
                    $display("FAIL age_issue%0d: got v=%0b op=%0h a=%0h b=%0h dst=%0h, want v=1 op=%0h a=%0h b=%0h dst=%0h",
                             k, alu_valid, alu_op, alu_vala, alu_valb, alu_dst_tag, e.op, e.a, e.b, e.dst);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (count !== 3'd0 || alu_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL age_drain: count=%0d alu_valid=%0b, want 0 0", count, alu_valid);
        end
    endtask

    task automatic test_full();
        alu_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_disp(PLUS_OP, 64'(i * 16), 1, 0, 64'(i), 1, 0, 4'(i), 1, 64'(i * 16), 64'(i));
            @(negedge clk);
        end
        idle();
        vectors++;
        if (count !== 3'd4 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full: count=%0d in_ready=%0b, want 4 0", count, in_ready);
        end
        set_disp(PLUS_OP, 64'h90, 1, 0, 64'h91, 1, 0, 4'd9, 0, 0, 0);
        @(negedge clk);
        idle();
        vectors++;
        if (count !== 3'd4) begin
            miscompares++;
            $display("FAIL full_drop: count=%0d, want 4", count);
        end
        alu_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                alu_ready = 1'b0;
                vectors++;
                if (in_ready !== 1'b1 || count !== 3'd3) begin
                    miscompares++;
                    $display("FAIL ready_after_fire: in_ready=%0b count=%0d, want 1 3", in_ready, count);
                end
                set_disp(PLUS_OP, 64'h50, 1, 0, 64'h5, 1, 0, 4'd5, 1, 64'h50, 64'h5);
                alu_ready = 1'b1;
            end
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL full_issue%0d: scoreboard empty, alu_valid=%0b", k, alu_valid);
            end else begin
                e = sb.pop_front();
                if (alu_valid !== 1'b1 || alu_vala !== e.a || alu_valb !== e.b || alu_dst_tag !== e.dst) begin
                    miscompares++;
                    $display("FAIL full_issue%0d: got v=%0b a=%0h b=%0h dst=%0h, want v=1 a=%0h b=%0h dst=%0h",
                             k, alu_valid, alu_vala, alu_valb, alu_dst_tag, e.a, e.b, e.dst);
                end
            end
            @(negedge clk);
        end
        idle();
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL simultaneous: count=%0d, want 3", count);
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL full_drain%0d: scoreboard empty, alu_valid=%0b", k, alu_valid);
            end else begin
                e = sb.pop_front();
                if (alu_valid !== 1'b1 || alu_vala !== e.a || alu_valb !== e.b || alu_dst_tag !== e.dst) begin
                    miscompares++;
                    $display("FAIL full_drain%0d: got v=%0b a=%0h b=%0h dst=%0h, want v=1 a=%0h b=%0h dst=%0h",
                             k, alu_valid, alu_vala, alu_valb, alu_dst_tag, e.a, e.b, e.dst);
                end
            end
            @(negedge clk);
        end
        vectors++;
        if (count !== 3'd0 || alu_valid !== 1'b0 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL full_end: count=%0d alu_valid=%0b pending=%0d, want 0 0 0", count, alu_valid, sb.size());
        end
    endtask

    task automatic test_flush();
        alu_ready = 1'b0;
        set_disp(PLUS_OP, 64'h1, 1, 0, 64'h2, 1, 0, 4'd1, 0, 0, 0);
        @(negedge clk);
        set_disp(PLUS_OP, 64'h3, 1, 0, 64'h0, 0, 4'd4, 4'd2, 0, 0, 0);
        @(negedge clk);
        set_disp(PLUS_OP, 64'h5, 1, 0, 64'h6, 1, 0, 4'd3, 0, 0, 0);
        @(negedge clk);
        set_disp(PLUS_OP, 64'h7, 1, 0, 64'h8, 1, 0, 4'd4, 0, 0, 0);
        cdb(4'd4, 64'h55);
        flush = 1'b1;
        vectors++;
        if (count !== 3'd3) begin
            miscompares++;
            $display("FAIL flush_prefill: count=%0d, want 3", count);
        end
        @(negedge clk);
        idle();
        vectors++;
        if (count !== 3'd0 || alu_valid !== 1'b0 || in_ready !== 1'b1 || alu_vala !== 64'd0) begin
            miscompares++;
            $display("FAIL flush: count=%0d alu_valid=%0b in_ready=%0b vala=%0h, want 0 0 1 0",
                     count, alu_valid, in_ready, alu_vala);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_age_order();
        test_full();
        test_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
